// File: rtl/labs_energy_iter.sv
// labs_energy_iter: iterative LABS (low-autocorrelation binary sequence) energy
// evaluator. A candidate sequence is accepted in IDLE, one aperiodic
// autocorrelation lag C_k is evaluated per cycle in CALC, and the summed
// energy E = sum C_k^2 is held in DONE until the downstream takes it.
// The lowest energy seen since reset or clear_best is tracked on the side.
module labs_energy_iter #(
    parameter int MAX_N   = 16,
    parameter int E_WIDTH = 20,
    parameter int N_W     = $clog2(MAX_N + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MAX_N-1:0]   i_seq,
    input  logic [N_W-1:0]     i_n,
    input  logic               i_valid,
    output logic               i_ready,
    output logic [MAX_N-1:0]   o_seq,
    output logic [N_W-1:0]     o_n,
    output logic [E_WIDTH-1:0] o_e,
    output logic               o_valid,
    input  logic               o_ready,
    input  logic               clear_best,
    output logic [E_WIDTH-1:0] best_e,
    output logic [MAX_N-1:0]   best_seq,
    output logic [N_W-1:0]     best_n,
    output logic               best_valid
);

    localparam int CW = N_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [MAX_N-1:0]   seq_r;
    logic [N_W-1:0]     n_r;
    logic [N_W-1:0]     k_r;
    logic [E_WIDTH-1:0] acc_r;
    logic               o_valid_r;

    logic [E_WIDTH-1:0] best_e_r;
    logic [MAX_N-1:0]   best_seq_r;
    logic [N_W-1:0]     best_n_r;
    logic               best_valid_r;

    logic                  accept_s;
    logic [N_W-1:0]        n_eff_s;
    logic [MAX_N-1:0]      in_mask_s;
    logic [MAX_N-1:0]      seq_in_s;
    logic [N_W-1:0]        nk_s;
    logic [MAX_N-1:0]      lag_mask_s;
    logic [MAX_N-1:0]      diff_s;
    logic [N_W-1:0]        pc_s;
    logic signed [CW-1:0]  c_s;
    logic signed [2*CW-1:0] csq_s;
    logic [E_WIDTH-1:0]    acc_nxt_s;
    logic                  last_lag_s;
    logic                  enter_done_s;
    logic [E_WIDTH-1:0]    result_e_s;
    logic [MAX_N-1:0]      result_seq_s;
    logic [N_W-1:0]        result_n_s;

    // Number of set bits in a sequence-wide vector.
    function automatic logic [N_W-1:0] popcount(input logic [MAX_N-1:0] v);
        logic [N_W-1:0] cnt;
        cnt = {N_W{1'b0}};
        for (int i = 0; i < MAX_N; i++) begin
            cnt = cnt + {{(N_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Candidate conditioning: clamp N to MAX_N and zero the bits beyond N.
    always_comb begin
        accept_s = i_valid & i_ready;
        if (i_n > N_W'(MAX_N)) begin
            n_eff_s = N_W'(MAX_N);
        end else begin
            n_eff_s = i_n;
        end
        in_mask_s = {MAX_N{1'b0}};
        for (int i = 0; i < MAX_N; i++) begin
            in_mask_s[i] = (N_W'(i) < n_eff_s);
        end
        seq_in_s = i_seq & in_mask_s;
    end

    // Lag datapath: C_k = (N-k) - 2*mismatches over the N-k overlapping pairs.
    always_comb begin
        nk_s       = n_r - k_r;
        lag_mask_s = {MAX_N{1'b0}};
        for (int i = 0; i < MAX_N; i++) begin
            lag_mask_s[i] = (N_W'(i) < nk_s);
        end
        diff_s     = (seq_r ^ (seq_r >> k_r)) & lag_mask_s;
        pc_s       = popcount(diff_s);
        c_s        = $signed({2'b00, nk_s}) - $signed({1'b0, pc_s, 1'b0});
        csq_s      = c_s * c_s;
        acc_nxt_s  = acc_r + E_WIDTH'($unsigned(csq_s));
        last_lag_s = (k_r == (n_r - N_W'(1)));
    end

    // Result that would be committed on an edge entering DONE.
    always_comb begin
        if (state_r == CALC) begin
            enter_done_s = last_lag_s;
            result_e_s   = acc_nxt_s;
            result_seq_s = seq_r;
            result_n_s   = n_r;
        end else if (state_r == IDLE) begin
            enter_done_s = accept_s & (n_eff_s < N_W'(2));
            result_e_s   = {E_WIDTH{1'b0}};
            result_seq_s = seq_in_s;
            result_n_s   = n_eff_s;
        end else begin
            enter_done_s = 1'b0;
            result_e_s   = {E_WIDTH{1'b0}};
            result_seq_s = {MAX_N{1'b0}};
            result_n_s   = {N_W{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (n_eff_s < N_W'(2)) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (last_lag_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (o_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: accept only when idle and not held in reset.
    always_comb begin
        if ((state_r == IDLE) && !rst) begin
            i_ready = 1'b1;
        end else begin
            i_ready = 1'b0;
        end
    end

    // Working registers: latch candidate, accumulate one lag per cycle, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_r     <= {MAX_N{1'b0}};
            n_r       <= {N_W{1'b0}};
            k_r       <= N_W'(1);
            acc_r     <= {E_WIDTH{1'b0}};
            o_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        seq_r     <= seq_in_s;
                        n_r       <= n_eff_s;
                        k_r       <= N_W'(1);
                        acc_r     <= {E_WIDTH{1'b0}};
                        o_valid_r <= (n_eff_s < N_W'(2));
                    end
                end
                CALC: begin
                    acc_r <= acc_nxt_s;
                    k_r   <= k_r + N_W'(1);
                    if (last_lag_s) begin
                        o_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid_r <= 1'b0;
                    end
                end
                default: o_valid_r <= 1'b0;
            endcase
        end
    end

    // Best-so-far tracker; a new strictly lower result wins, a clear that
    // coincides with a result still keeps that result.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_e_r     <= {E_WIDTH{1'b1}};
            best_seq_r   <= {MAX_N{1'b0}};
            best_n_r     <= {N_W{1'b0}};
            best_valid_r <= 1'b0;
        end else if (enter_done_s &&
                     (clear_best || !best_valid_r || (result_e_s < best_e_r))) begin
            best_e_r     <= result_e_s;
            best_seq_r   <= result_seq_s;
            best_n_r     <= result_n_s;
            best_valid_r <= 1'b1;
        end else if (clear_best) begin
            best_e_r     <= {E_WIDTH{1'b1}};
            best_valid_r <= 1'b0;
        end
    end

    assign o_seq      = seq_r;
    assign o_n        = n_r;
    assign o_e        = acc_r;
    assign o_valid    = o_valid_r;
    assign best_e     = best_e_r;
    assign best_seq   = best_seq_r;
    assign best_n     = best_n_r;
    assign best_valid = best_valid_r;

endmodule

// File: tb/tb_labs_energy_iter.sv
// Self-checking bench for labs_energy_iter: directed LABS vectors, handshake
// and reset corner cases, then randomized candidates, all against an
// autocorrelation model computed directly from +1/-1 element products.
module tb_labs_energy_iter;

    localparam int MAX_N   = 16;
    localparam int E_WIDTH = 20;
    localparam int N_W     = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [MAX_N-1:0]   i_seq;
    logic [N_W-1:0]     i_n;
    logic               i_valid;
    logic               i_ready;
    logic [MAX_N-1:0]   o_seq;
    logic [N_W-1:0]     o_n;
    logic [E_WIDTH-1:0] o_e;
    logic               o_valid;
    logic               o_ready;
    logic               clear_best;
    logic [E_WIDTH-1:0] best_e;
    logic [MAX_N-1:0]   best_seq;
    logic [N_W-1:0]     best_n;
    logic               best_valid;

    int total  = 0;
    int passed = 0;

    // Reference best-so-far state.
    int          m_bv;
    int          m_be;
    logic [15:0] m_bs;
    int          m_bn;

    labs_energy_iter dut (
        .clk(clk), .rst(rst), .i_seq(i_seq), .i_n(i_n), .i_valid(i_valid),
        .i_ready(i_ready), .o_seq(o_seq), .o_n(o_n), .o_e(o_e),
        .o_valid(o_valid), .o_ready(o_ready), .clear_best(clear_best),
        .best_e(best_e), .best_seq(best_seq), .best_n(best_n),
        .best_valid(best_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Energy from the definition: C_k = sum s_i*s_{i+k}, E = sum C_k^2.
    function automatic int energy(input logic [15:0] s, input int n);
        int e;
        int c;
        e = 0;
        for (int k = 1; k < n; k++) begin
            c = 0;
            for (int i = 0; i + k < n; i++) c += (s[i] == s[i+k]) ? 1 : -1;
            e += c * c;
        end
        return e;
    endfunction

    task automatic model_reset_best();
        m_bv = 0; m_be = 32'h000F_FFFF; m_bs = 16'h0000; m_bn = 0;
    endtask

    task automatic check_best(input string tag);
        chk({tag, ".best_valid"}, 32'(best_valid), 32'(m_bv));
        if (m_bv != 0) begin
            chk({tag, ".best_e"},   32'(best_e),   32'(m_be));
            chk({tag, ".best_seq"}, 32'(best_seq), 32'(m_bs));
            chk({tag, ".best_n"},   32'(best_n),   32'(m_bn));
        end else begin
            chk({tag, ".best_e_ones"}, 32'(best_e), 32'h000F_FFFF);
        end
    endtask

    // Offer one candidate, check latency, result, best tracking, hold and handshake.
    task automatic run(input string tag, input logic [15:0] seq, input int n,
                       input int hold, input bit clr);
        int ne;
        logic [15:0] ms;
        int e;
        int edges;
        ne = (n > MAX_N) ? MAX_N : n;
        ms = 16'h0000;
        for (int i = 0; i < ne; i++) ms[i] = seq[i];
        e = energy(ms, ne);

        @(negedge clk);
        chk({tag, ".i_ready"}, 32'(i_ready), 32'd1);
        i_seq = seq; i_n = N_W'(n); i_valid = 1'b1; clear_best = clr;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            clear_best = 1'b0;
            i_seq   = 16'($urandom);
            i_n     = N_W'($urandom_range(0, 31));
            i_valid = 1'($urandom_range(0, 1));
        end while (!o_valid && edges < 64);

        chk({tag, ".latency"}, 32'(edges), 32'((ne < 2) ? 1 : ne));
        chk({tag, ".o_e"},   32'(o_e),   32'(e));
        chk({tag, ".o_seq"}, 32'(o_seq), 32'(ms));
        chk({tag, ".o_n"},   32'(o_n),   32'(ne));
        if (clr || m_bv == 0 || e < m_be) begin
            m_bv = 1; m_be = e; m_bs = ms; m_bn = ne;
        end
        check_best(tag);

        for (int h = 0; h < hold; h++) begin
            i_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(o_valid), 32'd1);
            chk({tag, ".hold_e"},     32'(o_e),     32'(e));
            chk({tag, ".hold_seq"},   32'(o_seq),   32'(ms));
            chk({tag, ".hold_ready"}, 32'(i_ready), 32'd0);
        end

        o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_ready = 1'b0;
        i_valid = 1'b0;
        chk({tag, ".post_valid"}, 32'(o_valid), 32'd0);
        chk({tag, ".post_ready"}, 32'(i_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; i_seq = 16'h0000; i_n = 5'd0; i_valid = 1'b0;
        o_ready = 1'b0; clear_best = 1'b0;
        model_reset_best();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.i_ready",    32'(i_ready),    32'd0);
        chk("rst.o_valid",    32'(o_valid),    32'd0);
        chk("rst.o_e",        32'(o_e),        32'd0);
        chk("rst.o_seq",      32'(o_seq),      32'd0);
        chk("rst.o_n",        32'(o_n),        32'd0);
        chk("rst.best_valid", 32'(best_valid), 32'd0);
        chk("rst.best_e",     32'(best_e),     32'h000F_FFFF);
        chk("rst.best_seq",   32'(best_seq),   32'd0);
        chk("rst.best_n",     32'(best_n),     32'd0);
        rst = 1'b0;
        #1;
        chk("rst.release_ready", 32'(i_ready), 32'd1);

        run("n4",      16'h0007, 4,  0, 1'b0);
        run("barker",  16'h159F, 13, 0, 1'b0);
        run("barker2", 16'hF59F, 13, 2, 1'b0);

        @(negedge clk); clear_best = 1'b1;
        @(negedge clk); clear_best = 1'b0;
        model_reset_best();
        check_best("clr1");

        run("ff8",   16'h00FF, 8, 0, 1'b0);
        run("n4b",   16'h0007, 4, 0, 1'b0);
        run("ff8b",  16'h00FF, 8, 1, 1'b0);

        @(negedge clk); clear_best = 1'b1;
        @(negedge clk); clear_best = 1'b0;
        model_reset_best();
        check_best("clr2");

        run("n1",     16'hFFFF, 1, 0, 1'b0);
        run("n0clr",  16'h1234, 0, 0, 1'b1);
        run("n20",    16'hFFFF, 20, 10, 1'b0);

        // Reset in the middle of an N=13 computation (lag 5 pending).
        @(negedge clk);
        i_seq = 16'h159F; i_n = 5'd13; i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid.i_ready_rst", 32'(i_ready),    32'd0);
        chk("mid.o_valid",     32'(o_valid),    32'd0);
        chk("mid.best_valid",  32'(best_valid), 32'd0);
        rst = 1'b0;
        model_reset_best();
        #1;
        chk("mid.i_ready_rel", 32'(i_ready), 32'd1);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("mid.o_valid_late", 32'(o_valid), 32'd0);
        check_best("mid");

        for (int r = 0; r < 25; r++) begin
            run("rand", 16'($urandom), int'($urandom_range(0, 20)),
                int'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/labs_energy_iter.md
LABS_ENERGY_ITER -- requirements
Module: labs_energy_iter

Interface
REQ-001 Parameter MAX_N, default 16, maximum sequence length in bits (>=2).
REQ-002 Parameter E_WIDTH, default 20, energy width; energy arithmetic wraps modulo 2^E_WIDTH, and MAX_N=16 never overflows at the default.
REQ-003 Parameter N_W, default $clog2(MAX_N+1), width of length fields.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_seq  input  MAX_N  candidate sequence; bit i = element s_i (1 -> +1, 0 -> -1).
REQ-007 i_n  input  N_W  sequence length N for this candidate.
REQ-008 i_valid  input  1  candidate offered.
REQ-009 i_ready  output  1  block accepts a candidate.
REQ-010 o_seq  output  MAX_N  accepted sequence, bits >= N zeroed.
REQ-011 o_n  output  N_W  effective N of the result.
REQ-012 o_e  output  E_WIDTH  energy E = sum_{k=1..N-1} C_k^2.
REQ-013 o_valid  output  1  result held.
REQ-014 o_ready  input  1  downstream takes the result.
REQ-015 clear_best  input  1  clears best-so-far tracking.
REQ-016 best_e  output  E_WIDTH  lowest energy seen since reset/clear.
REQ-017 best_seq  output  MAX_N  sequence producing best_e.
REQ-018 best_n  output  N_W  N of best_seq.
REQ-019 best_valid  output  1  best_* fields meaningful.

Function
REQ-020 Three-state FSM: IDLE, CALC, DONE.
REQ-021 i_ready SHALL be 1 only in IDLE with rst low; accept = i_valid & i_ready.
REQ-022 On accept: latch masked i_seq and effective N = min(i_n, MAX_N); clear accumulator; set lag k=1; go to CALC if N>=2, else go to DONE with o_e=0.
REQ-023 CALC, one lag per cycle: C_k = (N-k) - 2*popcount((seq ^ (seq>>k)) & ((1<<(N-k))-1)), signed; accumulator += C_k^2; k++.
REQ-024 CALC exits to DONE on the edge processing k=N-1; o_valid therefore rises N-1 edges after the accepting edge (1 edge for N<2).
REQ-025 DONE: o_valid=1; o_seq, o_n, o_e held stable until o_ready=1; the handshake edge returns FSM to IDLE; no overlap of accept and result (i_ready=0 in CALC and DONE).
REQ-026 i_valid outside IDLE SHALL be ignored; i_seq/i_n changes after accept SHALL not affect the result.
REQ-027 On the edge entering DONE: if best_valid=0 or o_e < best_e (strict, unsigned), load best_e/best_seq/best_n from the result and set best_valid=1; ties keep the earlier entry.
REQ-028 clear_best=1 sets best_valid=0 and best_e=all-ones; if it coincides with a DONE entry, the new result is loaded and best_valid=1.
REQ-029 Best comparison is across all N values without normalisation.

Reset
REQ-030 rst=1 at an edge forces IDLE, o_valid=0, o_seq=0, o_n=0, o_e=0, best_valid=0, best_e=all-ones, best_seq=0, best_n=0, accumulator=0, k=1.
REQ-031 rst mid-CALC or mid-DONE aborts the computation with no result or best update; i_ready=0 while rst is high and 1 on the first cycle after release.

Verification
REQ-032 N=4, i_seq=16'h0007 -> o_e=2 (C=1,0,-1), o_valid 3 edges after accept, best_e=2.
REQ-033 N=13 Barker, i_seq=16'h159F -> o_e=6, latency 12 edges; i_seq=16'hF59F with N=13 -> identical o_e=6 and o_seq=16'h159F.
REQ-034 N=8, i_seq=16'h00FF -> o_e=140; then N=4 16'h0007 -> best_e=2, best_seq=16'h0007; then 16'h00FF N=8 again -> best unchanged; clear_best -> best_valid=0.
REQ-035 i_n=1 -> o_e=0 after 1 edge; i_n=20 -> o_n=16 with all-ones seq gives o_e=1240.
REQ-036 o_ready=0 for 10 cycles in DONE with i_valid=1 -> o_* stable, i_ready=0, no second accept; o_ready=1 -> IDLE next edge.
REQ-037 rst pulsed at k=5 of an N=13 run -> o_valid stays 0, best_valid=0, i_ready=1 the cycle after release.
